// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, types and helpers for the FFT address path
package fft_pkg;
  localparam int LOG2N  = 8;
  localparam int N      = 1 << LOG2N;
  localparam int RD_LAT = 1;
  localparam int BF_LAT = 3;
  localparam int DLY    = RD_LAT + BF_LAT;
  localparam int SW     = $clog2(LOG2N);
  typedef logic [LOG2N-1:0] addr_t;
  typedef logic [LOG2N-2:0] tw_t;
  typedef logic [SW-1:0]    stage_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_e;
  function automatic addr_t bit_reverse(input addr_t a);
    addr_t r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_wb_delay.sv
// fft_wb_delay: valid/address shift line turning read pairs into write-backs
module fft_wb_delay
  import fft_pkg::*;
#(
  parameter int DEPTH = DLY
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_valid,
  input  addr_t i_x1,
  input  addr_t i_x2,
  output logic  o_wr_en,
  output addr_t o_wr_x1,
  output addr_t o_wr_x2,
  output logic  o_near_empty
);
  logic [DEPTH-1:0] r_v;
  addr_t            r_x1 [DEPTH];
  addr_t            r_x2 [DEPTH];
  // shift every pending write one slot toward the tail each cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_x1[i] <= '0;
        r_x2[i] <= '0;
      end
    end else begin
      r_v     <= {r_v[DEPTH-2:0], i_valid};
      r_x1[0] <= i_x1;
      r_x2[0] <= i_x2;
      for (int i = 1; i < DEPTH; i++) begin
        r_x1[i] <= r_x1[i-1];
        r_x2[i] <= r_x2[i-1];
      end
    end
  end
  assign o_wr_en      = r_v[DEPTH-1];
  assign o_wr_x1      = r_x1[DEPTH-1];
  assign o_wr_x2      = r_x2[DEPTH-1];
  // only the last two slots may still hold writes: the final one leaves on the next edge
  assign o_near_empty = ~|r_v[DEPTH-3:0];
endmodule

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: radix-2 DIT in-place FFT read/twiddle/write-back address sequencer
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_start,
  output logic   o_busy,
  output logic   o_done,
  output stage_t o_stage,
  output logic   o_rd_en,
  output addr_t  o_rd_x1_addr,
  output addr_t  o_rd_x2_addr,
  output tw_t    o_tw_addr,
  output logic   o_wr_en,
  output addr_t  o_wr_x1_addr,
  output addr_t  o_wr_x2_addr
);
  state_e            r_state, w_state_nx;
  logic [LOG2N-2:0]  r_k;
  stage_t            r_stage;
  logic              w_near_empty, w_settled, w_issue;
  addr_t             w_h, w_grp, w_pos, w_x1, w_x2;
  tw_t               w_tw;
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end
  // next-state and butterfly address decode
  always_comb begin
    w_issue    = r_state == S_ISSUE;
    w_settled  = ~o_rd_en & w_near_empty;
    w_state_nx = r_state == S_IDLE  ? (i_start ? S_ISSUE : S_IDLE) :
                 r_state == S_ISSUE ? (&r_k ? S_DRAIN : S_ISSUE) :
                 r_state == S_DRAIN ? (!w_settled ? S_DRAIN :
                                       r_stage == stage_t'(LOG2N-1) ? S_FINISH : S_ISSUE) :
                 S_IDLE;
    w_h   = addr_t'(1) << r_stage;
    w_grp = addr_t'(r_k) >> r_stage;
    w_pos = addr_t'(r_k) & (w_h - addr_t'(1));
    w_x1  = ((w_grp << r_stage) << 1) | w_pos;
    w_x2  = w_x1 + w_h;
    w_tw  = tw_t'(w_pos << (stage_t'(LOG2N-1) - r_stage));
  end
  // butterfly index and stage counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_stage <= '0;
    end else begin
      r_k     <= w_issue ? r_k + 1'b1 : '0;
      r_stage <= r_state == S_IDLE ? '0 :
                 (r_state == S_DRAIN && w_state_nx == S_ISSUE) ? r_stage + 1'b1 : r_stage;
    end
  end
  // registered read-side and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_stage      <= '0;
      o_rd_en      <= 1'b0;
      o_rd_x1_addr <= '0;
      o_rd_x2_addr <= '0;
      o_tw_addr    <= '0;
    end else begin
      o_busy       <= r_state != S_IDLE;
      o_done       <= r_state == S_FINISH;
      o_stage      <= r_state == S_IDLE ? '0 : r_stage;
      o_rd_en      <= w_issue;
      o_rd_x1_addr <= w_issue ? w_x1 : '0;
      o_rd_x2_addr <= w_issue ? w_x2 : '0;
      o_tw_addr    <= w_issue ? w_tw : '0;
    end
  end
  fft_wb_delay #(.DEPTH(DLY)) u_wb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (o_rd_en),
    .i_x1         (o_rd_x1_addr),
    .i_x2         (o_rd_x2_addr),
    .o_wr_en      (o_wr_en),
    .o_wr_x1      (o_wr_x1_addr),
    .o_wr_x2      (o_wr_x2_addr),
    .o_near_empty (w_near_empty)
  );
endmodule

// File: tb/tb_fft_addr_gen.sv
// tb_fft_addr_gen: directed table-driven bench for the FFT address sequencer
module tb_fft_addr_gen;
  import fft_pkg::*;
  logic clk = 0, rst_n = 0, i_start = 0;
  logic o_busy, o_done, o_rd_en, o_wr_en;
  stage_t o_stage;
  addr_t o_rd_x1_addr, o_rd_x2_addr, o_wr_x1_addr, o_wr_x2_addr;
  tw_t o_tw_addr;
  always #5 clk = ~clk;
  fft_addr_gen dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_stage(o_stage), .o_rd_en(o_rd_en), .o_rd_x1_addr(o_rd_x1_addr),
    .o_rd_x2_addr(o_rd_x2_addr), .o_tw_addr(o_tw_addr), .o_wr_en(o_wr_en),
    .o_wr_x1_addr(o_wr_x1_addr), .o_wr_x2_addr(o_wr_x2_addr)
  );
  typedef struct {int s; int k; int x1; int x2; int tw;} vec_t;
  vec_t tv [10];
  int total = 0, bad = 0;
  time t0 = 0;
  logic mon = 0;
  int mc, n_rd, n_wr, first_wr, fx1, fx2, last_wr, done_cnt, done_cyc, busy_cnt, first_busy, last_busy;
  int first_rd [8];
  int cap_x1 [1024], cap_x2 [1024], cap_tw [1024], cap_st [1024], cap_cyc [1024];
  int w_x1 [1024], w_x2 [1024], w_cyc [1024];
  int hits [8][256];
  function automatic int cyc_now();
    return int'(($time - t0) / 10);
  endfunction
  task automatic chk(input string n, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask
  task automatic clear_mon();
    n_rd = 0; n_wr = 0; first_wr = -1; fx1 = -1; fx2 = -1; last_wr = -1;
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; first_busy = -1; last_busy = -1;
    for (int s = 0; s < 8; s++) begin
      first_rd[s] = -1;
      for (int a = 0; a < 256; a++) hits[s][a] = 0;
    end
  endtask
  always @(negedge clk) if (mon) begin
    mc = cyc_now();
    if (o_rd_en) begin
      if (n_rd < 1024) begin
        cap_x1[n_rd] = o_rd_x1_addr; cap_x2[n_rd] = o_rd_x2_addr; cap_tw[n_rd] = o_tw_addr;
        cap_st[n_rd] = o_stage; cap_cyc[n_rd] = mc;
        if (n_rd % 128 == 0) first_rd[n_rd/128] = mc;
      end
      n_rd++;
    end
    if (o_wr_en) begin
      if (n_wr == 0) begin first_wr = mc; fx1 = o_wr_x1_addr; fx2 = o_wr_x2_addr; end
      if (n_wr < 1024) begin
        w_x1[n_wr] = o_wr_x1_addr; w_x2[n_wr] = o_wr_x2_addr; w_cyc[n_wr] = mc;
        hits[n_wr/128][o_wr_x1_addr]++;
        hits[n_wr/128][o_wr_x2_addr]++;
      end
      last_wr = mc;
      n_wr++;
    end
    if (o_done) begin done_cnt++; done_cyc = mc; end
    if (o_busy) begin busy_cnt++; if (first_busy < 0) first_busy = mc; last_busy = mc; end
  end
  task automatic arm();
    @(posedge clk);
    t0 = $time;
    clear_mon();
    mon = 1;
    #1 i_start = 0;
  endtask
  task automatic kick();
    @(negedge clk);
    i_start = 1;
    arm();
  endtask
  task automatic wait_cyc(input int n);
    while (cyc_now() < n) @(negedge clk);
  endtask
  task automatic run_check(input string tag);
    int m, cov;
    wait_cyc(1065);
    mon = 0;
    for (int i = 0; i < 10; i++) begin
      int idx;
      idx = tv[i].s * 128 + tv[i].k;
      chk({tag, "_x1"}, cap_x1[idx], tv[i].x1);
      chk({tag, "_x2"}, cap_x2[idx], tv[i].x2);
      chk({tag, "_tw"}, cap_tw[idx], tv[i].tw);
      chk({tag, "_stage"}, cap_st[idx], tv[i].s);
      chk({tag, "_rdcyc"}, cap_cyc[idx], 1 + 132 * tv[i].s + tv[i].k);
    end
    chk({tag, "_n_rd"}, n_rd, 1024);
    chk({tag, "_n_wr"}, n_wr, 1024);
    chk({tag, "_first_rd0"}, first_rd[0], 1);
    chk({tag, "_first_rd1"}, first_rd[1], 133);
    chk({tag, "_first_wr"}, first_wr, 5);
    chk({tag, "_first_wr_x1"}, fx1, 0);
    chk({tag, "_first_wr_x2"}, fx2, 1);
    chk({tag, "_last_wr"}, last_wr, 1056);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_cyc"}, done_cyc, 1057);
    chk({tag, "_busy_first"}, first_busy, 1);
    chk({tag, "_busy_last"}, last_busy, 1057);
    chk({tag, "_busy_cnt"}, busy_cnt, 1057);
    m = 0;
    for (int i = 0; i < 1024; i++)
      if (w_x1[i] != cap_x1[i] || w_x2[i] != cap_x2[i] || w_cyc[i] != cap_cyc[i] + 4) m++;
    chk({tag, "_wr_follow"}, m, 0);
    cov = 0;
    for (int s = 0; s < 8; s++)
      for (int a = 0; a < 256; a++) if (hits[s][a] != 1) cov++;
    chk({tag, "_wr_cover"}, cov, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int snap;
    tv[0] = '{0, 0, 0, 1, 0};     tv[1] = '{0, 1, 2, 3, 0};
    tv[2] = '{1, 1, 1, 3, 64};    tv[3] = '{3, 10, 18, 26, 32};
    tv[4] = '{7, 5, 5, 133, 5};   tv[5] = '{7, 127, 127, 255, 127};
    tv[6] = '{0, 127, 254, 255, 0}; tv[7] = '{2, 5, 9, 13, 32};
    tv[8] = '{6, 64, 128, 192, 0}; tv[9] = '{4, 23, 39, 55, 56};
    repeat (3) @(negedge clk);
    chk("reset_outs", int'(|{o_busy, o_done, o_stage, o_rd_en, o_rd_x1_addr, o_rd_x2_addr,
        o_tw_addr, o_wr_en, o_wr_x1_addr, o_wr_x2_addr}), 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    kick();
    run_check("plain");
    kick();
    wait_cyc(50); i_start = 1; @(negedge clk); i_start = 0;
    wait_cyc(600); i_start = 1; @(negedge clk); i_start = 0;
    run_check("restart_ign");
    kick();
    wait_cyc(299); rst_n = 0;
    @(negedge clk); rst_n = 1;
    chk("midrst_outs", int'(|{o_busy, o_done, o_stage, o_rd_en, o_rd_x1_addr, o_rd_x2_addr,
        o_tw_addr, o_wr_en, o_wr_x1_addr, o_wr_x2_addr}), 0);
    snap = n_wr;
    wait_cyc(340);
    chk("midrst_no_wr", n_wr, snap);
    chk("midrst_busy", int'(o_busy), 0);
    mon = 0;
    kick();
    run_check("after_rst");
    kick();
    for (int i = 0; i < 1200 && !o_done; i++) @(negedge clk);
    chk("b2b_done1", o_done ? cyc_now() : -1, 1057);
    i_start = 1;
    arm();
    run_check("b2b");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
